// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - motion state, velocity type and default physics constants
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PROBE,
        ST_WAIT_RD,
        ST_UPDATE
    } motion_state_t;

    typedef logic signed [5:0] velocity_t;

    localparam int DEF_FLOOR_Y   = 448;
    localparam int DEF_TICK_DIV  = 2000000;
    localparam int DEF_JUMP_V    = 15;
    localparam int DEF_GRAVITY   = 1;
    localparam int DEF_MAX_FALL  = 8;
    localparam int DEF_RD_LAT    = 1;

endpackage

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - decoded keyboard codes shared by the input and game blocks
package vga_pkg;

    localparam logic [3:0] key_none = 4'h0;
    localparam logic [3:0] key_W    = 4'h1;
    localparam logic [3:0] key_A    = 4'h2;
    localparam logic [3:0] key_S    = 4'h3;
    localparam logic [3:0] key_D    = 4'h4;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running divider producing a one-cycle motion tick
module tick_gen #(
    parameter int TICK_DIV = 2000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/player_motion_y.sv
// rtl/player_motion_y.sv - player vertical motion: gravity, jump, ground probe
// Optional air jump enabled by defining DOUBLE_JUMP_EN.
module player_motion_y
    import game_pkg::*;
    import vga_pkg::*;
#(
    parameter int         YPOS_W      = 9,
    parameter int         XPOS_W      = 11,
    parameter int         ADR_X_W     = 9,
    parameter int         ADR_Y_W     = 7,
    parameter int         SCALE_SHIFT = 2,
    parameter int         PROBE_OFS   = 2,
    parameter int         FLOOR_Y     = DEF_FLOOR_Y,
    parameter int         TICK_DIV    = DEF_TICK_DIV,
    parameter int         JUMP_V      = DEF_JUMP_V,
    parameter int         GRAVITY     = DEF_GRAVITY,
    parameter int         MAX_FALL    = DEF_MAX_FALL,
    parameter int         RD_LAT      = DEF_RD_LAT,
    parameter logic [3:0] SOLID_COLOR = 4'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 key,
    input  logic                       freeze,
    input  logic [XPOS_W-1:0]          xpos,
    input  logic [3:0]                 rgb_pixel,
    output logic [ADR_X_W+ADR_Y_W-1:0] pixel_adr,
    output logic [YPOS_W-1:0]          player_ypos,
    output logic [5:0]                 velocity,
    output logic                       grounded,
    output logic                       update_done
);

    localparam int SW = YPOS_W + 2;
    localparam int WW = $clog2(RD_LAT + 1);
    localparam logic [YPOS_W-1:0]     FLOOR_YV   = YPOS_W'(FLOOR_Y);
    localparam logic signed [SW-1:0]  FLOOR_S    = SW'(FLOOR_Y);
    localparam logic signed [6:0]     MAX_FALL_S = 7'(MAX_FALL);
    localparam velocity_t             JUMP_VEL   = velocity_t'(-JUMP_V);
    localparam velocity_t             MAX_VEL    = velocity_t'(MAX_FALL);

    motion_state_t                state_q;
    logic [WW-1:0]                wait_cnt_q;
    logic [YPOS_W-1:0]            ypos_q;
    velocity_t                    vel_q;
    logic                         grounded_q;
    logic [ADR_X_W+ADR_Y_W-1:0]   pixel_adr_q;
    logic                         update_done_q;
    logic                         jump_pending_q;
    logic                         key_prev_q;
    logic [3:0]                   rgb_q;
`ifdef DOUBLE_JUMP_EN
    logic                         air_used_q;
    logic                         air_used_d;
`endif

    logic                         tick;
    logic                         key_is_w;
    logic                         key_edge;
    logic                         ground;
    logic                         jump_taken;
    logic signed [6:0]            vel_inc;
    velocity_t                    vel_d;
    logic                         grounded_d;
    logic signed [SW-1:0]         y_sum;
    logic [YPOS_W-1:0]            ypos_d;
    logic [ADR_Y_W-1:0]           probe_row;
    logic [ADR_X_W-1:0]           probe_col;

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign key_is_w  = (key == key_W);
    assign key_edge  = key_is_w && !key_prev_q;
    assign probe_row = ADR_Y_W'((ypos_q >> SCALE_SHIFT) + YPOS_W'(PROBE_OFS));
    assign probe_col = ADR_X_W'(xpos >> SCALE_SHIFT);

    always_comb begin
        ground     = (rgb_q == SOLID_COLOR) || (ypos_q >= FLOOR_YV);
        jump_taken = 1'b0;
        vel_inc    = {vel_q[5], vel_q} + 7'(GRAVITY);
        vel_d      = vel_q;
`ifdef DOUBLE_JUMP_EN
        air_used_d = air_used_q;
`endif
        if (jump_pending_q && ground) begin
            vel_d      = JUMP_VEL;
            jump_taken = 1'b1;
`ifdef DOUBLE_JUMP_EN
        end else if (jump_pending_q && !air_used_q) begin
            vel_d      = JUMP_VEL;
            jump_taken = 1'b1;
            air_used_d = 1'b1;
`endif
        end else if (ground && !vel_q[5]) begin
            vel_d = '0;
        end else if (vel_inc > MAX_FALL_S) begin
            vel_d = MAX_VEL;
        end else begin
            vel_d = vel_inc[5:0];
        end
`ifdef DOUBLE_JUMP_EN
        if (ground) begin
            air_used_d = 1'b0;
        end
`endif
        // Standing only when resting on something; a jump leaves the ground at once.
        grounded_d = ground && !jump_taken && !vel_q[5];
        y_sum      = $signed({2'b00, ypos_q}) + {{(SW-6){vel_d[5]}}, vel_d};
        ypos_d     = y_sum[YPOS_W-1:0];
        if (y_sum <= 0) begin
            ypos_d = '0;
            vel_d  = '0;
        end else if (y_sum >= FLOOR_S) begin
            ypos_d     = FLOOR_YV;
            vel_d      = '0;
            grounded_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            wait_cnt_q     <= '0;
            ypos_q         <= FLOOR_YV;
            vel_q          <= '0;
            grounded_q     <= 1'b1;
            pixel_adr_q    <= '0;
            update_done_q  <= 1'b0;
            jump_pending_q <= 1'b0;
            key_prev_q     <= 1'b0;
            rgb_q          <= '0;
`ifdef DOUBLE_JUMP_EN
            air_used_q     <= 1'b0;
`endif
        end else begin
            update_done_q <= 1'b0;
            key_prev_q    <= key_is_w;
            if (key_edge) begin
                jump_pending_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick && !freeze) begin
                        state_q <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    pixel_adr_q <= {probe_row, probe_col};
                    wait_cnt_q  <= '0;
                    state_q     <= ST_WAIT_RD;
                end
                ST_WAIT_RD: begin
                    if (wait_cnt_q == WW'(RD_LAT)) begin
                        rgb_q   <= rgb_pixel;
                        state_q <= ST_UPDATE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_UPDATE: begin
                    ypos_q         <= ypos_d;
                    vel_q          <= vel_d;
                    grounded_q     <= grounded_d;
                    jump_pending_q <= key_edge;
`ifdef DOUBLE_JUMP_EN
                    air_used_q     <= air_used_d;
`endif
                    update_done_q  <= 1'b1;
                    state_q        <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pixel_adr   = pixel_adr_q;
    assign player_ypos = ypos_q;
    assign velocity    = vel_q;
    assign grounded    = grounded_q;
    assign update_done = update_done_q;

endmodule

// File: tb/tb_player_motion_y.sv
// tb/tb_player_motion_y.sv - directed bench for player_motion_y (TICK_DIV=4, RD_LAT=1)
module tb_player_motion_y;
    import vga_pkg::*;

    localparam int FLOOR = 448;
    localparam logic [3:0] SOLID = 4'h0;
    localparam logic [3:0] AIR   = 4'hF;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic        freeze;
    logic [10:0] xpos;
    logic [3:0]  rgb_pixel;
    logic [15:0] pixel_adr;
    logic [8:0]  player_ypos;
    logic [5:0]  velocity;
    logic        grounded;
    logic        update_done;

    int errors = 0;
    int checks = 0;
    int my, mv, mg, mair;

    player_motion_y #(
        .TICK_DIV(4),
        .RD_LAT  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .freeze     (freeze),
        .xpos       (xpos),
        .rgb_pixel  (rgb_pixel),
        .pixel_adr  (pixel_adr),
        .player_ypos(player_ypos),
        .velocity   (velocity),
        .grounded   (grounded),
        .update_done(update_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference physics, advanced once per expected update.
    task automatic model_update(input bit pend, input bit solid);
        int gnd, jumped, ny;
        gnd    = (solid || my >= FLOOR) ? 1 : 0;
        jumped = 0;
        mg     = 0;
        if (pend && gnd != 0) begin
            mv = -15; jumped = 1;
`ifdef DOUBLE_JUMP_EN
        end else if (pend && mair == 0) begin
            mv = -15; jumped = 1; mair = 1;
`endif
        end else if (gnd != 0 && mv >= 0) begin
            mv = 0; mg = 1;
        end else begin
            mv = (mv + 1 > 8) ? 8 : mv + 1;
        end
        if (gnd != 0) mair = 0;
        ny = my + mv;
        if (ny <= 0) begin
            ny = 0; mv = 0;
        end else if (ny >= FLOOR) begin
            ny = FLOOR; mv = 0; mg = 1;
        end
        my = ny;
    endtask

    task automatic wait_update();
        int n;
        n = 0;
        while (n < 64 && update_done !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        check("update_seen", update_done, 1);
    endtask

    // kmode: 0 leave key as is, 1 one-cycle press, 2 press and hold
    task automatic step(input int kmode, input logic [3:0] rgb, input string tag);
        rgb_pixel = rgb;
        if (kmode != 0) begin
            key = key_none;
            @(negedge clk);
            key = key_W;
            @(negedge clk);
            if (kmode == 1) key = key_none;
        end
        model_update(kmode != 0, rgb == SOLID);
        @(posedge clk); #1;
        wait_update();
        check({tag, "_y"}, player_ypos, my);
        check({tag, "_v"}, $signed(velocity), mv);
        check({tag, "_g"}, grounded, mg);
    endtask

    initial begin
        int first, cnt, guard;
        rst = 1'b1; key = key_none; freeze = 1'b0; xpos = 11'd600; rgb_pixel = AIR;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ypos", player_ypos, 448);
        check("rst_vel", $signed(velocity), 0);
        check("rst_grounded", grounded, 1);
        check("rst_adr", pixel_adr, 0);
        check("rst_done", update_done, 0);

        @(negedge clk);
        rst = 1'b0;
        first = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (update_done === 1'b1) begin
                first = k;
                break;
            end
        end
        check("first_update_cycle", first, 8);
        check("idle_ypos", player_ypos, 448);
        check("idle_vel", $signed(velocity), 0);
        check("idle_grounded", grounded, 1);
        my = 448; mv = 0; mg = 1; mair = 0;

        step(2, AIR, "jump");
        check("jump_y_hand", player_ypos, 433);
        check("jump_v_hand", $signed(velocity), -15);
        step(0, AIR, "hold1");
        check("hold1_v_hand", $signed(velocity), -14);
        step(0, AIR, "hold2");
        check("hold2_y_hand", player_ypos, 406);
        key = key_none;

        step(1, AIR, "air_edge2");
`ifdef DOUBLE_JUMP_EN
        check("air_edge2_hand", $signed(velocity), -15);
`else
        check("air_edge2_hand", $signed(velocity), -12);
`endif
        step(1, AIR, "air_edge3");
`ifdef DOUBLE_JUMP_EN
        check("air_edge3_hand", $signed(velocity), -14);
`else
        check("air_edge3_hand", $signed(velocity), -11);
`endif

        guard = 0;
        while (mg == 0 && guard < 80) begin
            step(0, AIR, "fall");
            guard++;
        end
        check("land_y", player_ypos, 448);
        check("land_v", $signed(velocity), 0);
        check("land_g", grounded, 1);

        guard = 0;
        while (my > 0 && guard < 40) begin
            step(1, SOLID, "climb");
            guard++;
        end
        check("ceiling_steps", guard, 30);
        check("ceiling_y", player_ypos, 0);
        check("ceiling_v", $signed(velocity), 0);

        @(negedge clk);
        freeze = 1'b1;
        cnt = 0;
        repeat (16) begin
            @(posedge clk); #1;
            if (update_done === 1'b1) cnt++;
        end
        check("freeze_updates", cnt, 0);
        check("freeze_y", player_ypos, 0);
        freeze = 1'b0;

        for (int i = 0; i < 5; i++) step(0, AIR, "drop");
        check("drop_y_hand", player_ypos, 15);
        check("drop_v_hand", $signed(velocity), 5);
        step(0, SOLID, "solid_land");
        check("solid_y_hand", player_ypos, 15);
        check("solid_v_hand", $signed(velocity), 0);
        check("solid_g_hand", grounded, 1);
        check("probe_adr", pixel_adr, (5 << 9) | 150);

        guard = 0;
        mg = 0;
        while (!(mg != 0 && my == FLOOR) && guard < 80) begin
            step(0, AIR, "fall2");
            guard++;
        end
        check("final_y", player_ypos, 448);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
